// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and a saturating bubble counter.
// Drives PC / IF/ID write enables combinationally from the current EX contents.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7_5,
  input  logic             id_reg_write,
  input  logic             id_mem_to_reg,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_branch,
  input  logic             id_alu_src,
  input  logic [1:0]       id_alu_op,
  input  logic             flush,
  input  logic             hold,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7_5,
  output logic             ex_reg_write,
  output logic             ex_mem_to_reg,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_branch,
  output logic             ex_alu_src,
  output logic [1:0]       ex_alu_op,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] bubble_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             vld_p1;
  logic [XLEN-1:0]  pc_p1, rs1_data_p1, rs2_data_p1, imm_p1;
  logic [4:0]       rs1_p1, rs2_p1, rd_p1;
  logic [2:0]       funct3_p1;
  logic             funct7_5_p1;
  logic             reg_write_p1, mem_to_reg_p1, mem_read_p1, mem_write_p1, branch_p1, alu_src_p1;
  logic [1:0]       alu_op_p1;
  logic [CNT_W-1:0] bubble_cnt_p1;
  logic             hz_p0;

  // ID stage: hazard check against the instruction currently in EX
  assign hz_p0 = id_valid & vld_p1 & mem_read_p1 & (rd_p1 != 5'd0) &
                 ((rd_p1 == id_rs1) | (rd_p1 == id_rs2));

  assign load_use_stall = hz_p0 & ~flush & ~hold;
  assign pc_write       = flush | ~(hold | hz_p0);
  assign ifid_write     = flush | ~(hold | hz_p0);

  // ID -> EX boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1        <= 1'b0;
      pc_p1         <= '0;
      rs1_data_p1   <= '0;
      rs2_data_p1   <= '0;
      imm_p1        <= '0;
      rs1_p1        <= '0;
      rs2_p1        <= '0;
      rd_p1         <= '0;
      funct3_p1     <= '0;
      funct7_5_p1   <= 1'b0;
      reg_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      branch_p1     <= 1'b0;
      alu_src_p1    <= 1'b0;
      alu_op_p1     <= '0;
      bubble_cnt_p1 <= '0;
    end else begin
      if (flush || !hold) begin
        pc_p1       <= id_pc;
        rs1_data_p1 <= id_rs1_data;
        rs2_data_p1 <= id_rs2_data;
        imm_p1      <= id_imm;
        rs1_p1      <= id_rs1;
        rs2_p1      <= id_rs2;
        rd_p1       <= id_rd;
        funct3_p1   <= id_funct3;
        funct7_5_p1 <= id_funct7_5;
      end
      if (flush || (!hold && hz_p0)) begin
        vld_p1        <= 1'b0;
        reg_write_p1  <= 1'b0;
        mem_to_reg_p1 <= 1'b0;
        mem_read_p1   <= 1'b0;
        mem_write_p1  <= 1'b0;
        branch_p1     <= 1'b0;
        alu_src_p1    <= 1'b0;
        alu_op_p1     <= '0;
      end else if (!hold) begin
        vld_p1        <= id_valid;
        reg_write_p1  <= id_reg_write  & id_valid;
        mem_to_reg_p1 <= id_mem_to_reg & id_valid;
        mem_read_p1   <= id_mem_read   & id_valid;
        mem_write_p1  <= id_mem_write  & id_valid;
        branch_p1     <= id_branch     & id_valid;
        alu_src_p1    <= id_alu_src    & id_valid;
        alu_op_p1     <= id_alu_op & {2{id_valid}};
      end
      if (!flush && !hold && hz_p0)
        bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
    end
  end

  assign ex_valid      = vld_p1;
  assign ex_pc         = pc_p1;
  assign ex_rs1_data   = rs1_data_p1;
  assign ex_rs2_data   = rs2_data_p1;
  assign ex_imm        = imm_p1;
  assign ex_rs1        = rs1_p1;
  assign ex_rs2        = rs2_p1;
  assign ex_rd         = rd_p1;
  assign ex_funct3     = funct3_p1;
  assign ex_funct7_5   = funct7_5_p1;
  assign ex_reg_write  = reg_write_p1;
  assign ex_mem_to_reg = mem_to_reg_p1;
  assign ex_mem_read   = mem_read_p1;
  assign ex_mem_write  = mem_write_p1;
  assign ex_branch     = branch_p1;
  assign ex_alu_src    = alu_src_p1;
  assign ex_alu_op     = alu_op_p1;
  assign bubble_count  = bubble_cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios plus randomized traffic,
// compared against a transaction-level reference model.
module tb_id_ex_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc, rs1d, rs2d, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      f3;
    logic            f7;
    logic            rw, m2r, mr, mw, br, as;
    logic [1:0]      aop;
  } st_t;

  typedef struct packed {
    st_t             s;
    logic [CNT_W-1:0] c;
  } sexp_t;

  typedef struct packed {
    logic st, pw, iw;
  } cexp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush, hold;
  st_t  in_s, act_s;

  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [2:0]       ex_funct3;
  logic             ex_funct7_5;
  logic             ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src;
  logic [1:0]       ex_alu_op;
  logic             pc_write, ifid_write, load_use_stall;
  logic [CNT_W-1:0] bubble_count;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(in_s.valid), .id_pc(in_s.pc), .id_rs1_data(in_s.rs1d), .id_rs2_data(in_s.rs2d),
    .id_imm(in_s.imm), .id_rs1(in_s.rs1), .id_rs2(in_s.rs2), .id_rd(in_s.rd),
    .id_funct3(in_s.f3), .id_funct7_5(in_s.f7),
    .id_reg_write(in_s.rw), .id_mem_to_reg(in_s.m2r), .id_mem_read(in_s.mr),
    .id_mem_write(in_s.mw), .id_branch(in_s.br), .id_alu_src(in_s.as), .id_alu_op(in_s.aop),
    .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7_5(ex_funct7_5),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op),
    .pc_write(pc_write), .ifid_write(ifid_write), .load_use_stall(load_use_stall),
    .bubble_count(bubble_count)
  );

  assign act_s = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
                  ex_funct3, ex_funct7_5, ex_reg_write, ex_mem_to_reg, ex_mem_read,
                  ex_mem_write, ex_branch, ex_alu_src, ex_alu_op};

  int errors = 0;
  int checks = 0;
  sexp_t sq[$];
  cexp_t cq[$];

  // Reference model: architectural view of what EX should hold
  st_t              m;
  logic [CNT_W-1:0] mcnt;
  bit               known = 1'b0;

  function automatic st_t as_bubble(input st_t s);
    st_t r = s;
    r.valid = 1'b0;
    r.rw = 1'b0; r.m2r = 1'b0; r.mr = 1'b0; r.mw = 1'b0; r.br = 1'b0; r.as = 1'b0;
    r.aop = 2'b00;
    return r;
  endfunction

  function automatic st_t rnd_in();
    st_t s;
    s.valid = ($urandom_range(0, 3) != 0);
    s.pc    = $urandom;
    s.rs1d  = $urandom;
    s.rs2d  = $urandom;
    s.imm   = $urandom;
    s.rs1   = 5'($urandom_range(0, 7));
    s.rs2   = 5'($urandom_range(0, 7));
    s.rd    = 5'($urandom_range(0, 7));
    s.f3    = 3'($urandom_range(0, 7));
    s.f7    = 1'($urandom_range(0, 1));
    s.rw    = 1'($urandom_range(0, 1));
    s.m2r   = 1'($urandom_range(0, 1));
    s.mr    = ($urandom_range(0, 2) == 0);
    s.mw    = 1'($urandom_range(0, 1));
    s.br    = 1'($urandom_range(0, 1));
    s.as    = 1'($urandom_range(0, 1));
    s.aop   = 2'($urandom_range(0, 3));
    return s;
  endfunction

  function automatic st_t load_op(input logic [4:0] rd, input logic [4:0] rs1);
    st_t s = '0;
    s.valid = 1'b1; s.mr = 1'b1; s.rw = 1'b1; s.m2r = 1'b1; s.as = 1'b1;
    s.rd = rd; s.rs1 = rs1; s.rs2 = 5'd0; s.f3 = 3'b010;
    s.pc = $urandom; s.rs1d = $urandom; s.imm = 32'd4;
    return s;
  endfunction

  // Called right after a falling edge with inputs already applied.
  task automatic cycle();
    st_t              nx;
    logic [CNT_W-1:0] nc;
    logic             hz;
    #2;
    hz = in_s.valid && m.valid && m.mr && (m.rd != 5'd0) &&
         ((m.rd == in_s.rs1) || (m.rd == in_s.rs2));
    if (known)
      cq.push_back('{hz && !flush && !hold, flush || !(hold || hz), flush || !(hold || hz)});
    nx = m;
    nc = mcnt;
    if (!rst_n) begin
      nx = '0;
      nc = '0;
    end else if (flush) begin
      nx = as_bubble(in_s);
    end else if (hold) begin
      nx = m;
    end else if (hz) begin
      nx = as_bubble(in_s);
      nc = (mcnt == {CNT_W{1'b1}}) ? mcnt : mcnt + 1'b1;
    end else begin
      nx = in_s.valid ? in_s : as_bubble(in_s);
    end
    if (!rst_n) known = 1'b1;
    m    = nx;
    mcnt = nc;
    if (known) sq.push_back('{nx, nc});
    @(posedge clk);
    @(negedge clk);
  endtask

  // Registered-output monitor
  initial begin
    sexp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sq.size() > 0) begin
        e = sq.pop_front();
        checks++;
        if (act_s !== e.s) begin
          errors++;
          $display("FAIL ex_state t=%0t got=%h want=%h", $time, act_s, e.s);
        end
        checks++;
        if (bubble_count !== e.c) begin
          errors++;
          $display("FAIL bubble_count t=%0t got=%0d want=%0d", $time, bubble_count, e.c);
        end
      end
    end
  end

  // Combinational-output monitor
  initial begin
    cexp_t c;
    forever begin
      @(negedge clk);
      #3;
      if (cq.size() > 0) begin
        c = cq.pop_front();
        checks++;
        if ({load_use_stall, pc_write, ifid_write} !== {c.st, c.pw, c.iw}) begin
          errors++;
          $display("FAIL enables t=%0t got stall/pcw/ifw=%b%b%b want=%b%b%b", $time,
                   load_use_stall, pc_write, ifid_write, c.st, c.pw, c.iw);
        end
      end
    end
  end

  initial begin
    m = '0;
    mcnt = '0;
    rst_n = 1'b0; flush = 1'b0; hold = 1'b0;
    in_s = rnd_in();
    @(negedge clk);

    // Reset with random ID inputs
    for (int i = 0; i < 2; i++) begin
      in_s = rnd_in();
      cycle();
    end
    rst_n = 1'b1;

    // Normal R-type pass, then the same with id_valid low
    in_s = '0;
    in_s.valid = 1'b1; in_s.rw = 1'b1; in_s.aop = 2'b10; in_s.rd = 5'd6;
    in_s.rs1d = 32'h11; in_s.rs2d = 32'h22; in_s.rs1 = 5'd1; in_s.rs2 = 5'd2;
    cycle();
    in_s = rnd_in();
    in_s.valid = 1'b0; in_s.rw = 1'b1; in_s.mr = 1'b1; in_s.aop = 2'b11;
    cycle();

    // Load-use: lw x5 then add using x5
    in_s = load_op(5'd5, 5'd2);
    cycle();
    in_s = '0;
    in_s.valid = 1'b1; in_s.rw = 1'b1; in_s.aop = 2'b10;
    in_s.rs1 = 5'd5; in_s.rs2 = 5'd1; in_s.rd = 5'd8;
    cycle();
    cycle();
    in_s = '0;
    cycle();

    // No false stall: rd = x0, and non-matching indices
    in_s = load_op(5'd0, 5'd1);
    cycle();
    in_s = '0; in_s.valid = 1'b1; in_s.rw = 1'b1; in_s.rs1 = 5'd0;
    cycle();
    in_s = load_op(5'd7, 5'd1);
    cycle();
    in_s = '0; in_s.valid = 1'b1; in_s.rw = 1'b1; in_s.rs1 = 5'd3; in_s.rs2 = 5'd4;
    cycle();

    // Flush coincident with a hazard
    in_s = load_op(5'd5, 5'd1);
    cycle();
    in_s = '0; in_s.valid = 1'b1; in_s.rw = 1'b1; in_s.rs1 = 5'd5;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();

    // Hold coincident with a hazard for three cycles, then one bubble
    in_s = load_op(5'd5, 5'd1);
    cycle();
    in_s = '0; in_s.valid = 1'b1; in_s.rw = 1'b1; in_s.rs2 = 5'd5; in_s.rd = 5'd9;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    hold = 1'b0;
    cycle();
    cycle();

    // Randomized traffic with occasional flush, hold and reset
    for (int i = 0; i < 400; i++) begin
      in_s  = rnd_in();
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 59) != 0);
      cycle();
    end
    flush = 1'b0; hold = 1'b0;

    // Saturation: fresh reset, then a stream of dependent loads
    rst_n = 1'b0;
    in_s = '0;
    cycle();
    rst_n = 1'b1;
    in_s = load_op(5'd5, 5'd5);
    for (int i = 0; i < 40; i++) cycle();
    in_s = '0;
    cycle();
    cycle();

    @(posedge clk);
    #3;
    checks++;
    if (sq.size() != 0 || cq.size() != 0) begin
      errors++;
      $display("FAIL drain leftover state=%0d enables=%0d want=0", sq.size(), cq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
